// File: rtl/add_sub.sv
// Sign-magnitude adder/subtractor with registered result and ALU flags (SF, ZF, DZF).
// Optional in_valid/out_valid handshake is enabled by defining ADD_SUB_VALID_EN.
module add_sub #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
`ifdef ADD_SUB_VALID_EN
  input  logic         in_valid,
`endif
  input  logic         OP,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic [W:0]   R,
  output logic         SF,
  output logic         ZF,
`ifdef ADD_SUB_VALID_EN
  output logic         out_valid,
`endif
  output logic         DZF
);

  logic [W-1:0] mag_a, mag_b;
  logic         sign_a, sign_b_eff;
  logic         a_ge_b;
  logic [W-1:0] mag_res;
  logic         sign_res;
  logic [W:0]   r_d, r_q;
  logic         capture;

  // Zero-extended magnitudes give the sum one spare bit, so it never overflows.
  assign mag_a = {1'b0, A[W-2:0]};
  assign mag_b = {1'b0, B[W-2:0]};

  // A zero magnitude is treated as +0 regardless of its sign bit.
  assign sign_a     = A[W-1] & (|A[W-2:0]);
  assign sign_b_eff = (B[W-1] & (|B[W-2:0])) ^ OP;
  assign a_ge_b     = (mag_a >= mag_b);

  always_comb begin
    mag_res  = '0;
    sign_res = 1'b0;
    if (sign_a == sign_b_eff) begin
      mag_res  = mag_a + mag_b;
      sign_res = sign_a;
    end else if (a_ge_b) begin
      mag_res  = mag_a - mag_b;
      sign_res = sign_a;
    end else begin
      mag_res  = mag_b - mag_a;
      sign_res = sign_b_eff;
    end
    r_d = {sign_res & (|mag_res), mag_res};
  end

`ifdef ADD_SUB_VALID_EN
  logic out_valid_q;

  assign capture = in_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
    end
  end

  assign out_valid = out_valid_q;
`else
  assign capture = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (capture) begin
      r_q <= r_d;
    end
  end

  // Flags are decoded from the registered result only, so no input-to-output path exists.
  assign R   = r_q;
  assign SF  = r_q[W];
  assign ZF  = ~(|r_q[W-1:0]);
  assign DZF = 1'b0;

endmodule

// File: tb/tb_add_sub.sv
// Directed and exhaustive-sweep bench for add_sub at W = 3.
// Handshake checks are compiled in when ADD_SUB_VALID_EN is defined.
module tb_add_sub;

  localparam int unsigned W = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         OP  = 1'b0;
  logic [W-1:0] A   = '0;
  logic [W-1:0] B   = '0;
  logic [W:0]   R;
  logic         SF, ZF, DZF;
`ifdef ADD_SUB_VALID_EN
  logic         in_valid = 1'b0;
  logic         out_valid;
`endif

  int n_checks = 0;
  int n_errors = 0;

  add_sub #(.W(W)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef ADD_SUB_VALID_EN
    .in_valid (in_valid),
    .out_valid(out_valid),
`endif
    .OP       (OP),
    .A        (A),
    .B        (B),
    .R        (R),
    .SF       (SF),
    .ZF       (ZF),
    .DZF      (DZF)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one operation between edges, then sample just after the capturing edge.
  task automatic apply(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    OP = op;
    A  = a;
    B  = b;
`ifdef ADD_SUB_VALID_EN
    in_valid = 1'b1;
`endif
    @(posedge clk);
    #1;
  endtask

  // Integer reference: decode operands, do the arithmetic, re-encode sign-magnitude.
  function automatic logic [W:0] model(input logic op, input logic [W-1:0] a,
                                       input logic [W-1:0] b);
    int va, vb, r;
    va = a[W-1] ? -int'(a[W-2:0]) : int'(a[W-2:0]);
    vb = b[W-1] ? -int'(b[W-2:0]) : int'(b[W-2:0]);
    r  = op ? va - vb : va + vb;
    if (r < 0) return {1'b1, W'(-r)};
    return {1'b0, W'(r)};
  endfunction

  function automatic logic [W-1:0] enc(input int v);
    if (v < 0) return {1'b1, (W-1)'(-v)};
    return {1'b0, (W-1)'(v)};
  endfunction

  initial begin
    // Reset with no clock edge yet.
    #2 rst = 1'b1;
    #1;
    check("rst_R", 32'(R), 32'h0);
    check("rst_SF", 32'(SF), 32'h0);
    check("rst_ZF", 32'(ZF), 32'h1);
    check("rst_DZF", 32'(DZF), 32'h0);
`ifdef ADD_SUB_VALID_EN
    check("rst_out_valid", 32'(out_valid), 32'h0);
`endif
    @(negedge clk);
    rst = 1'b0;

    apply(1'b0, 3'b011, 3'b011);
    check("add_pp_R", 32'(R), 32'h6);
    check("add_pp_SF", 32'(SF), 32'h0);
    check("add_pp_ZF", 32'(ZF), 32'h0);
`ifdef ADD_SUB_VALID_EN
    check("add_pp_out_valid", 32'(out_valid), 32'h1);
`endif

    apply(1'b0, 3'b111, 3'b111);
    check("add_nn_R", 32'(R), 32'he);
    check("add_nn_SF", 32'(SF), 32'h1);

    apply(1'b0, 3'b111, 3'b011);
    check("add_np_R", 32'(R), 32'h0);
    check("add_np_ZF", 32'(ZF), 32'h1);
    check("add_np_SF", 32'(SF), 32'h0);

    apply(1'b0, 3'b001, 3'b110);
    check("add_pn_R", 32'(R), 32'h9);
    check("add_pn_SF", 32'(SF), 32'h1);

    apply(1'b1, 3'b001, 3'b011);
    check("sub_pp_R", 32'(R), 32'ha);
    check("sub_pp_SF", 32'(SF), 32'h1);

    apply(1'b1, 3'b111, 3'b011);
    check("sub_np_R", 32'(R), 32'he);

    apply(1'b1, 3'b011, 3'b111);
    check("sub_pn_R", 32'(R), 32'h6);
    check("sub_pn_SF", 32'(SF), 32'h0);

    apply(1'b1, 3'b100, 3'b000);
    check("negzero_R", 32'(R), 32'h0);
    check("negzero_ZF", 32'(ZF), 32'h1);

    // Exhaustive sweep over -3..+3 for both operations.
    for (int op = 0; op < 2; op++) begin
      for (int va = -3; va <= 3; va++) begin
        for (int vb = -3; vb <= 3; vb++) begin
          apply(op[0], enc(va), enc(vb));
          check("sweep_R", 32'(R), 32'(model(op[0], enc(va), enc(vb))));
          check("sweep_DZF", 32'(DZF), 32'h0);
        end
      end
    end

    // Mid-stream reset discards the captured result.
    apply(1'b0, 3'b011, 3'b010);
    check("pre_rst_R", 32'(R), 32'h5);
    @(negedge clk);
    A = 3'b001;
    B = 3'b001;
    rst = 1'b1;
    #1;
    check("midrst_R", 32'(R), 32'h0);
    check("midrst_ZF", 32'(ZF), 32'h1);
    check("midrst_SF", 32'(SF), 32'h0);
`ifdef ADD_SUB_VALID_EN
    check("midrst_out_valid", 32'(out_valid), 32'h0);
    in_valid = 1'b0;
`endif
    @(posedge clk);
    #1;
    check("midrst_hold_R", 32'(R), 32'h0);
    @(negedge clk);
    rst = 1'b0;

`ifdef ADD_SUB_VALID_EN
    // No in_valid after reset: result and out_valid stay at reset values.
    A = 3'b011;
    B = 3'b001;
    @(posedge clk);
    #1;
    check("post_rst_idle_out_valid", 32'(out_valid), 32'h0);
    check("post_rst_idle_R", 32'(R), 32'h0);
    apply(1'b0, 3'b011, 3'b001);
    check("post_rst_R", 32'(R), 32'h4);
    check("post_rst_out_valid", 32'(out_valid), 32'h1);

    // in_valid low while operands change: R holds.
    @(negedge clk);
    in_valid = 1'b0;
    A = 3'b111;
    B = 3'b111;
    @(posedge clk);
    #1;
    check("hold_R", 32'(R), 32'h4);
    check("hold_out_valid", 32'(out_valid), 32'h0);
    @(negedge clk);
    A = 3'b001;
    OP = 1'b1;
    @(posedge clk);
    #1;
    check("hold2_R", 32'(R), 32'h4);
`else
    apply(1'b0, 3'b011, 3'b001);
    check("post_rst_R", 32'(R), 32'h4);
    check("post_rst_ZF", 32'(ZF), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
